// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_receiver                                                    |
// | Brief    : Oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for     |
// |            8E1 framing with even-parity checking.                           |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       i_CLK,
   input  logic       i_RESET,
   input  logic       i_CLK_EN,
   input  logic       i_RX,
   output logic [7:0] o_DATA_OUT,
   output logic       o_DATA_VALID,
   output logic       o_FRAMING_ERROR,
   output logic       o_PARITY_ERROR,
   output logic       o_BUSY
);

   localparam int                 c_CNT_W = $clog2(OVERSAMPLE);
   localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t             r_state;
   logic               r_rx_meta;
   logic               r_rx_sync;
   logic               r_rx_prev;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_cnt;
   logic [7:0]         r_shift;
   logic [7:0]         r_data_out;
   logic               r_valid;
   logic               r_ferr;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bit;
   logic               r_perr;
`endif

   // Line synchronizer runs every clock so the tick rate does not stretch metastability settling.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= i_RX;
         r_rx_sync <= r_rx_meta;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         r_state    <= S_IDLE;
         r_rx_prev  <= 1'b1;
         r_cnt      <= '0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_data_out <= 8'h00;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit  <= 1'b0;
         r_perr     <= 1'b0;
`endif
      end else begin
         // Pulses clear every clock so they last one cycle even with back-to-back ticks.
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr  <= 1'b0;
`endif
         if (i_CLK_EN) begin
            r_rx_prev <= r_rx_sync;
            case (r_state)
               S_IDLE: begin
                  if (!r_rx_sync && r_rx_prev) begin
                     r_state <= S_START;
                     r_cnt   <= '0;
                  end
               end
               S_START: begin
                  if (r_cnt == c_HALF) begin
                     r_cnt     <= '0;
                     r_bit_cnt <= 3'd0;
                     r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (r_cnt == c_LAST) begin
                     r_cnt              <= '0;
                     r_shift[r_bit_cnt] <= r_rx_sync;
                     r_bit_cnt          <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (r_cnt == c_LAST) begin
                     r_cnt     <= '0;
                     r_par_bit <= r_rx_sync;
                     r_state   <= S_STOP;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`endif
               S_STOP: begin
                  if (r_cnt == c_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                     if (r_rx_sync) begin
                        r_data_out <= r_shift;
                        r_valid    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        r_perr     <= (^r_shift) ^ r_par_bit;
`endif
                     end else begin
                        r_ferr <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_DATA_OUT      = r_data_out;
   assign o_DATA_VALID    = r_valid;
   assign o_FRAMING_ERROR = r_ferr;
   assign o_BUSY          = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_PARITY_ERROR  = r_perr;
`else
   assign o_PARITY_ERROR  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_receiver                                                 |
// | Brief    : Directed self-checking bench for uart_receiver (OVERSAMPLE=16).  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_receiver;

   localparam int c_OS = 16;

   logic       i_CLK;
   logic       i_RESET;
   logic       i_CLK_EN;
   logic       i_RX;
   logic [7:0] o_DATA_OUT;
   logic       o_DATA_VALID;
   logic       o_FRAMING_ERROR;
   logic       o_PARITY_ERROR;
   logic       o_BUSY;

   int total = 0;
   int bad   = 0;
   int div   = 1;
   int phase = 0;
   int n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0;
   logic [7:0] rx_q[$];

   uart_receiver #(.OVERSAMPLE(c_OS)) dut (
      .i_CLK          (i_CLK),
      .i_RESET        (i_RESET),
      .i_CLK_EN       (i_CLK_EN),
      .i_RX           (i_RX),
      .o_DATA_OUT     (o_DATA_OUT),
      .o_DATA_VALID   (o_DATA_VALID),
      .o_FRAMING_ERROR(o_FRAMING_ERROR),
      .o_PARITY_ERROR (o_PARITY_ERROR),
      .o_BUSY         (o_BUSY)
   );

   initial begin
      i_CLK = 1'b0;
      forever #5 i_CLK = ~i_CLK;
   end

   // Tick generator: one enable cycle every 'div' clocks.
   initial begin
      i_CLK_EN = 1'b1;
      forever begin
         @(posedge i_CLK);
         #1;
         phase    = (phase + 1 >= div) ? 0 : phase + 1;
         i_CLK_EN = (phase == 0);
      end
   end

   // Pulse monitor: counts every clock a pulse output is high.
   initial begin
      forever begin
         @(negedge i_CLK);
         if (o_DATA_VALID === 1'b1) begin
            n_valid++;
            rx_q.push_back(o_DATA_OUT);
         end
         if (o_FRAMING_ERROR === 1'b1) n_ferr++;
         if (o_PARITY_ERROR === 1'b1) n_perr++;
         if (o_DATA_VALID === 1'b1 && o_PARITY_ERROR === 1'b1) n_both++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      int guard = 0;
      do begin
         @(posedge i_CLK);
         guard++;
      end while (!i_CLK_EN && guard < 20);
      if (!i_CLK_EN) begin
         total++;
         bad++;
         $error("FAIL tick_timeout: observed=no tick expected=tick within 20 clocks");
      end
   endtask

   task automatic drive(input logic level, input int nticks);
      #1;
      i_RX = level;
      for (int k = 0; k < nticks; k++) wait_tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
      drive(1'b0, c_OS);
      for (int i = 0; i < 8; i++) drive(d[i], c_OS);
`ifdef UART_RX_PARITY_EN
      drive(par, c_OS);
`else
      if (par === 1'bx) $display("note: parity argument unused");
`endif
      drive(stop_bit, c_OS);
   endtask

   int v0, f0;

   initial begin
      i_RESET = 1'b1;
      i_RX    = 1'b1;
      repeat (4) @(posedge i_CLK);
      @(negedge i_CLK);
      check("rst_data",  {24'd0, o_DATA_OUT}, 32'h00);
      check("rst_valid", {31'd0, o_DATA_VALID}, 32'd0);
      check("rst_ferr",  {31'd0, o_FRAMING_ERROR}, 32'd0);
      check("rst_perr",  {31'd0, o_PARITY_ERROR}, 32'd0);
      check("rst_busy",  {31'd0, o_BUSY}, 32'd0);
      i_RESET = 1'b0;
      drive(1'b1, 8);

      // Single frame 0x80
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h80, 1'b1, 1'b1);
      drive(1'b1, 4);
      @(negedge i_CLK);
      check("f80_valid_cnt", n_valid - v0, 1);
      check("f80_data", {24'd0, o_DATA_OUT}, 32'h80);
      check("f80_busy", {31'd0, o_BUSY}, 32'd0);
      check("f80_ferr_cnt", n_ferr - f0, 0);

      // False start: 5 ticks low
      v0 = n_valid; f0 = n_ferr;
      drive(1'b0, 5);
      @(negedge i_CLK);
      check("false_busy_mid", {31'd0, o_BUSY}, 32'd1);
      drive(1'b1, 20);
      @(negedge i_CLK);
      check("false_busy_end", {31'd0, o_BUSY}, 32'd0);
      check("false_valid_cnt", n_valid - v0, 0);
      check("false_ferr_cnt", n_ferr - f0, 0);

      // Framing error followed by a held-low break
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h55, 1'b0, 1'b0);
      drive(1'b0, 40);
      @(negedge i_CLK);
      check("brk_ferr_cnt", n_ferr - f0, 1);
      check("brk_valid_cnt", n_valid - v0, 0);
      check("brk_busy", {31'd0, o_BUSY}, 32'd0);
      check("brk_data_held", {24'd0, o_DATA_OUT}, 32'h80);
      drive(1'b1, 20);
      @(negedge i_CLK);
      check("brk_busy_idle", {31'd0, o_BUSY}, 32'd0);

      // Back-to-back frames, one tick every third clock
      div = 3;
      rx_q.delete();
      v0 = n_valid;
      send_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      drive(1'b1, 8);
      @(negedge i_CLK);
      check("b2b_valid_cnt", n_valid - v0, 2);
      check("b2b_q_size", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check("b2b_first", {24'd0, rx_q[0]}, 32'hA5);
         check("b2b_second", {24'd0, rx_q[1]}, 32'h3C);
      end
      check("b2b_data", {24'd0, o_DATA_OUT}, 32'h3C);
      div = 1;
      drive(1'b1, 8);

      // Reset during bit 4 of frame 0x5A
      v0 = n_valid; f0 = n_ferr;
      drive(1'b0, c_OS);
      for (int i = 0; i < 4; i++) drive(1'(8'h5A >> i), c_OS);
      drive(1'b1, c_OS / 2);
      @(negedge i_CLK);
      check("mid_busy_before_rst", {31'd0, o_BUSY}, 32'd1);
      i_RESET = 1'b1;
      i_RX    = 1'b1;
      repeat (3) @(posedge i_CLK);
      @(negedge i_CLK);
      check("mrst_data", {24'd0, o_DATA_OUT}, 32'h00);
      check("mrst_busy", {31'd0, o_BUSY}, 32'd0);
      check("mrst_valid", {31'd0, o_DATA_VALID}, 32'd0);
      i_RESET = 1'b0;
      drive(1'b1, 20);
      @(negedge i_CLK);
      check("mrst_no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
      send_frame(8'h12, 1'b1, 1'b0);
      drive(1'b1, 4);
      @(negedge i_CLK);
      check("post_rst_valid_cnt", n_valid - v0, 1);
      check("post_rst_data", {24'd0, o_DATA_OUT}, 32'h12);

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight, so even parity requires 1; sending 0 must flag
      v0 = n_valid;
      begin
         int p0, b0;
         p0 = n_perr; b0 = n_both;
         send_frame(8'h07, 1'b1, 1'b0);
         drive(1'b1, 4);
         @(negedge i_CLK);
         check("par_valid_cnt", n_valid - v0, 1);
         check("par_perr_cnt", n_perr - p0, 1);
         check("par_together", n_both - b0, 1);
         check("par_data", {24'd0, o_DATA_OUT}, 32'h07);
      end
`else
      check("no_parity_pulses", n_perr, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
